// File: rtl/slug_vga_timing.sv
// Raster timing and registered colour/sync output stage for the SlugCross core.
// Optional `SLUG_VGA_BORDER_EN` draws a white one-pixel frame around the active area.
module slug_vga_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic [11:0] rgb_in,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        Hsync,
  output logic        Vsync,
  output logic        HBlank,
  output logic        VBlank,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters are 10 bits wide, so neither total may exceed 1024.
  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_total_check
    $error("slug_vga_timing: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_X = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS_X  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE_X  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_X = 11'(V_ACTIVE);
  localparam logic [10:0] V_SS_X  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE_X  = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [10:0] h_ext_s, v_ext_s;
  logic        hblank_s, vblank_s;
  logic        hsync_act_s, vsync_act_s;
  logic [11:0] colour_s;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblank_q, hblank_d;
  logic        vblank_q, vblank_d;
  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (ce_pix) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        if (v_q == V_LAST) begin
          v_d = 10'd0;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
        v_d = v_q;
      end
    end else begin
      h_d = h_q;
      v_d = v_q;
    end
  end

  // Widened compares keep sync-end bounds exact even when a total reaches 1024.
  always_comb begin
    h_ext_s     = {1'b0, h_q};
    v_ext_s     = {1'b0, v_q};
    hblank_s    = (h_ext_s >= H_ACT_X);
    vblank_s    = (v_ext_s >= V_ACT_X);
    hsync_act_s = (h_ext_s >= H_SS_X) && (h_ext_s < H_SE_X);
    vsync_act_s = (v_ext_s >= V_SS_X) && (v_ext_s < V_SE_X);
  end

`ifdef SLUG_VGA_BORDER_EN
  localparam logic [9:0] H_EDGE = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_EDGE = 10'(V_ACTIVE - 1);
  logic border_s;

  always_comb begin
    border_s = (h_q == 10'd0) || (h_q == H_EDGE) || (v_q == 10'd0) || (v_q == V_EDGE);
  end

  always_comb begin
    colour_s = 12'h000;
    if (hblank_s || vblank_s) begin
      colour_s = 12'h000;
    end else if (border_s) begin
      colour_s = 12'hFFF;
    end else begin
      colour_s = rgb_in;
    end
  end
`else
  always_comb begin
    colour_s = 12'h000;
    if (hblank_s || vblank_s) begin
      colour_s = 12'h000;
    end else begin
      colour_s = rgb_in;
    end
  end
`endif

  always_comb begin
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    hblank_d = hblank_q;
    vblank_d = vblank_q;
    rgb_d    = rgb_q;
    if (ce_pix) begin
      hsync_d  = hsync_act_s ? SYNC_POL : ~SYNC_POL;
      vsync_d  = vsync_act_s ? SYNC_POL : ~SYNC_POL;
      hblank_d = hblank_s;
      vblank_d = vblank_s;
      rgb_d    = colour_s;
    end else begin
      hsync_d  = hsync_q;
      vsync_d  = vsync_q;
      hblank_d = hblank_q;
      vblank_d = vblank_q;
      rgb_d    = rgb_q;
    end
  end

  // All seven video outputs load on the same edge, one pixel behind the counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q      <= 10'd0;
      v_q      <= 10'd0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      rgb_q    <= 12'h000;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      rgb_q    <= rgb_d;
    end
  end

  assign pix_x       = h_q;
  assign pix_y       = v_q;
  assign line_start  = (h_q == 10'd0);
  assign frame_start = (h_q == 10'd0) && (v_q == 10'd0);
  assign Hsync       = hsync_q;
  assign Vsync       = vsync_q;
  assign HBlank      = hblank_q;
  assign VBlank      = vblank_q;
  assign vgaRed      = rgb_q[11:8];
  assign vgaGreen    = rgb_q[7:4];
  assign vgaBlue     = rgb_q[3:0];

endmodule

// File: tb/tb_slug_vga_timing.sv
// Scoreboard bench for slug_vga_timing on a shrunken 25x19 raster so whole frames fit the run.
module tb_slug_vga_timing;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce_pix;
  logic [11:0] rgb_in;
  logic [9:0]  pix_x, pix_y;
  logic        line_start, frame_start, Hsync, Vsync, HBlank, VBlank;
  logic [3:0]  vgaRed, vgaGreen, vgaBlue;

  always #5 clk = ~clk;

  slug_vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .rgb_in(rgb_in),
    .pix_x(pix_x), .pix_y(pix_y), .line_start(line_start), .frame_start(frame_start),
    .Hsync(Hsync), .Vsync(Vsync), .HBlank(HBlank), .VBlank(VBlank),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue)
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        ls;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec = 0, n_err = 0;
  int   mh = 0, mv = 0;
  logic rgb_mode;
  logic [11:0] rgb_fix;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic obs_t cur_obs();
    obs_t o;
    o.x = pix_x; o.y = pix_y; o.ls = line_start; o.fs = frame_start;
    o.hs = Hsync; o.vs = Vsync; o.hb = HBlank; o.vb = VBlank;
    o.rgb = {vgaRed, vgaGreen, vgaBlue};
    return o;
  endfunction

  function automatic int next_h(input int h);
    return (h == HT - 1) ? 0 : h + 1;
  endfunction

  function automatic int next_v(input int h, input int v);
    if (h != HT - 1) return v;
    return (v == VT - 1) ? 0 : v + 1;
  endfunction

  // Expected outputs after a ce_pix edge taken at coordinate (h,v) with colour c.
  function automatic obs_t make_exp(input int h, input int v, input logic [11:0] c);
    obs_t e;
    int nh, nv;
    logic brd;
    nh = next_h(h);
    nv = next_v(h, v);
    e.x  = 10'(nh);
    e.y  = 10'(nv);
    e.ls = (nh == 0);
    e.fs = (nh == 0) && (nv == 0);
    e.hb = (h >= HA);
    e.vb = (v >= VA);
    e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
    e.vs = !((v >= VA + VF) && (v < VA + VF + VS));
`ifdef SLUG_VGA_BORDER_EN
    brd = (h == 0) || (h == HA - 1) || (v == 0) || (v == VA - 1);
`else
    brd = 1'b0;
`endif
    e.rgb = (e.hb || e.vb) ? 12'h000 : (brd ? 12'hFFF : c);
    return e;
  endfunction

  // Reference model: one expected observation per enabled clock edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mh <= 0;
      mv <= 0;
      exp_q.delete();
    end else if (ce_pix) begin
      exp_q.push_back(make_exp(mh, mv, rgb_in));
      mh <= next_h(mh);
      mv <= next_v(mh, mv);
    end
  end

  obs_t mon_e, mon_a, snap;
  logic was_run = 1'b0;
  logic count_en = 1'b0;
  int   win_cnt = 0, nb_cnt = 0, fff_cnt = 0, blank_bad = 0, hs_lo = 0, vs_lo = 0;
  int   ce_since = 0;
  logic fs_valid = 1'b0;

  // Monitor: compare against scoreboard on enabled edges, require hold otherwise.
  always @(posedge clk) begin
    #1;
    mon_a = cur_obs();
    if (reset_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("scoreboard", mon_a, mon_e);
      if (count_en) begin
        win_cnt++;
        if (!mon_a.hb && !mon_a.vb) begin
          nb_cnt++;
          if (mon_a.rgb == 12'hFFF) fff_cnt++;
        end else if (mon_a.rgb != 12'h000) begin
          blank_bad++;
        end
        if (!mon_a.hs) hs_lo++;
        if (!mon_a.vs) vs_lo++;
      end
      ce_since++;
      if (mon_a.fs) begin
        if (fs_valid) check("frame_period", ce_since, FRAME);
        fs_valid = 1'b1;
        ce_since = 0;
      end
    end else if (reset_n && was_run) begin
      check("hold", mon_a, snap);
    end
    if (!reset_n) fs_valid = 1'b0;
    snap    = mon_a;
    was_run = reset_n;
  end

  task automatic step(input logic ce);
    @(negedge clk);
    ce_pix = ce;
    rgb_in = rgb_mode ? {pix_x[3:0], pix_y[3:0], pix_x[7:4] ^ 4'h5} : rgb_fix;
  endtask

  task automatic wait_xy(input int x, input int y);
    int k;
    k = 0;
    while (!((pix_x == 10'(x)) && (pix_y == 10'(y))) && (k < 3000)) begin
      step(1'b1);
      k++;
    end
    check("wait_xy", {pix_y, pix_x}, {10'(y), 10'(x)});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pix_x"}, pix_x, 10'd0);
    check({tag, "_pix_y"}, pix_y, 10'd0);
    check({tag, "_hblank"}, HBlank, 1'b1);
    check({tag, "_vblank"}, VBlank, 1'b1);
    check({tag, "_hsync"}, Hsync, 1'b1);
    check({tag, "_vsync"}, Vsync, 1'b1);
    check({tag, "_rgb"}, {vgaRed, vgaGreen, vgaBlue}, 12'h000);
  endtask

  initial begin
    reset_n  = 1'b0;
    ce_pix   = 1'b1;
    rgb_mode = 1'b0;
    rgb_fix  = 12'hABC;
    rgb_in   = 12'hABC;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    check("rst_line_start", line_start, 1'b1);
    check("rst_frame_start", frame_start, 1'b1);

    // Release; outputs stay at reset values until the first enabled edge.
    reset_n = 1'b1;
    #1;
    check("rel_rgb", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
    check("rel_hblank", HBlank, 1'b1);
    @(posedge clk);
    #2;
`ifdef SLUG_VGA_BORDER_EN
    check("first_rgb", {vgaRed, vgaGreen, vgaBlue}, 12'hFFF);
`else
    check("first_rgb", {vgaRed, vgaGreen, vgaBlue}, 12'hABC);
`endif
    check("first_blank", {HBlank, VBlank}, 2'b00);
    check("first_pix_x", pix_x, 10'd1);

    // Coordinate-dependent colour over more than a frame.
    rgb_mode = 1'b1;
    repeat (FRAME + 50) step(1'b1);

    // One full frame of white: count visible/blank/sync cycles.
    rgb_mode = 1'b0;
    rgb_fix  = 12'hFFF;
    wait_xy(0, 0);
    count_en = 1'b1;
    begin
      int k;
      k = 0;
      while ((win_cnt < FRAME) && (k < 3000)) begin
        step(1'b1);
        k++;
      end
    end
    count_en = 1'b0;
    check("win_len", win_cnt, FRAME);
    check("nonblank_cycles", nb_cnt, HA * VA);
    check("fff_cycles", fff_cnt, HA * VA);
    check("blank_nonzero", blank_bad, 0);
    check("hsync_low", hs_lo, HS * VT);
    check("vsync_low", vs_lo, VS * HT);

    // Enable one clock in four; monitor enforces hold between enables.
    rgb_mode = 1'b1;
    for (int i = 0; i < 200; i++) step((i % 4) == 0);

    // Mid-frame asynchronous reset.
    wait_xy(10, 7);
    reset_n = 1'b0;
    #1;
    check_reset_state("midrst");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    step(1'b1);
    check("post_rst_x", pix_x, 10'd1);
    check("post_rst_y", pix_y, 10'd0);
    repeat (2 * FRAME + 10) step(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
